// File: rtl/hilo_capture.sv
// HI/LO result-capture stage behind the multiplier and divider.
// It waits out the product settle time or the divider handshake, then writes HI/LO and pulses done or err.
module hilo_capture #(
    parameter int SETTLE_CYCLES = 2,
    parameter int DIV_TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [63:0] p_in,
    input  logic [31:0] q_in,
    input  logic [31:0] r_in,
    input  logic        div_ready,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        DIVWAIT = 2'd2
    } state_t;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;

    // Counters are loaded one short so that the final action lands on edge N after start.
    localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] DIV_INIT    = 8'(DIV_TIMEOUT - 1);

    state_t     state;
    logic [7:0] cnt;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state  <= IDLE;
            cnt    <= '0;
            hi_out <= '0;
            lo_out <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MUL: begin
                                state <= SETTLE;
                                cnt   <= SETTLE_INIT;
                                busy  <= 1'b1;
                            end
                            OP_DIV: begin
                                state <= DIVWAIT;
                                cnt   <= DIV_INIT;
                                busy  <= 1'b1;
                            end
                            OP_MTHI: begin
                                hi_out <= wr_data;
                                done   <= 1'b1;
                            end
                            default: begin
                                lo_out <= wr_data;
                                done   <= 1'b1;
                            end
                        endcase
                    end
                end
                SETTLE: begin
                    if (cnt == 8'd0) begin
                        {hi_out, lo_out} <= p_in;
                        done  <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                DIVWAIT: begin
                    // A ready divider wins over an expiring timeout on the same edge.
                    if (div_ready) begin
                        lo_out <= q_in;
                        hi_out <= r_in;
                        done   <= 1'b1;
                        state  <= IDLE;
                        busy   <= 1'b0;
                    end else if (cnt == 8'd0) begin
                        err   <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_capture.sv
// Bench for hilo_capture: directed steps plus a randomized op mix.
// The reference model holds HI/LO and the edge at which each op completes.
module tb_hilo_capture;
    localparam int S = 2;
    localparam int T = 6;

    logic        clk = 1'b0;
    logic        clr, start, div_ready;
    logic [1:0]  op;
    logic [63:0] p_in;
    logic [31:0] q_in, r_in, wr_data;
    logic        busy, done, err;
    logic [31:0] hi_out, lo_out;

    int tests = 0;
    int fails = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    hilo_capture #(.SETTLE_CYCLES(S), .DIV_TIMEOUT(T)) dut (
        .clk(clk), .clr(clr), .start(start), .op(op), .p_in(p_in),
        .q_in(q_in), .r_in(r_in), .div_ready(div_ready), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err), .hi_out(hi_out), .lo_out(lo_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".hi"}, 64'(hi_out), 64'(m_hi));
        chk({tag, ".lo"}, 64'(lo_out), 64'(m_lo));
    endtask

    task automatic chk_flags(input string tag, input logic b, input logic d, input logic e);
        chk({tag, ".busy"}, 64'(busy), 64'(b));
        chk({tag, ".done"}, 64'(done), 64'(d));
        chk({tag, ".err"},  64'(err),  64'(e));
    endtask

    task automatic chk_idle(input string tag);
        chk_flags(tag, 1'b0, 1'b0, 1'b0);
        chk_regs(tag);
    endtask

    // Capture is the p_in present at edge S; earlier edges see garbage.
    task automatic do_mul(input logic [63:0] p, input bit poke);
        op = 2'b00; start = 1'b1; p_in = {$urandom, $urandom};
        tick;
        start = 1'b0;
        chk_flags("mul.e0", 1'b1, 1'b0, 1'b0);
        for (int e = 1; e < S; e++) begin
            p_in = {$urandom, $urandom};
            if (poke && e == 1) begin start = 1'b1; op = 2'b00; end
            tick;
            start = 1'b0;
            chk_flags("mul.wait", 1'b1, 1'b0, 1'b0);
        end
        p_in = p;
        tick;
        {m_hi, m_lo} = p;
        chk_flags("mul.cap", 1'b0, 1'b1, 1'b0);
        chk_regs("mul.cap");
        p_in = {$urandom, $urandom};
        tick;
        chk_idle("mul.after");
    endtask

    // k: edge with div_ready high (1..T captures), anything else times out at edge T.
    task automatic do_div(input int k, input logic [31:0] q, input logic [31:0] r, input bit stale);
        op = 2'b01; start = 1'b1; div_ready = 1'b0;
        tick;
        start = 1'b0;
        chk_flags("div.e0", 1'b1, 1'b0, 1'b0);
        for (int e = 1; e <= T; e++) begin
            div_ready = (e == k);
            q_in = (e == k) ? q : $urandom;
            r_in = (e == k) ? r : $urandom;
            tick;
            if (e == k) begin
                m_lo = q; m_hi = r;
                chk_flags("div.cap", 1'b0, 1'b1, 1'b0);
                chk_regs("div.cap");
                break;
            end else if (e == T) begin
                chk_flags("div.tmo", 1'b0, 1'b0, 1'b1);
                chk_regs("div.tmo");
            end else begin
                chk_flags("div.wait", 1'b1, 1'b0, 1'b0);
            end
        end
        div_ready = 1'b0;
        tick;
        chk_idle("div.after");
        if (stale) begin
            div_ready = 1'b1; q_in = $urandom; r_in = $urandom;
            tick;
            div_ready = 1'b0;
            chk_idle("div.stale");
        end
    endtask

    // Leaves start high so a following call lands on the very next edge.
    task automatic do_mt(input bit to_hi, input logic [31:0] d);
        op = to_hi ? 2'b10 : 2'b11; wr_data = d; start = 1'b1;
        tick;
        if (to_hi) m_hi = d; else m_lo = d;
        chk_flags(to_hi ? "mthi" : "mtlo", 1'b0, 1'b1, 1'b0);
        chk_regs(to_hi ? "mthi" : "mtlo");
    endtask

    initial begin
        clr = 1'b0; start = 1'b0; op = 2'b00; p_in = '0; q_in = '0; r_in = '0;
        div_ready = 1'b0; wr_data = '0;
        #1;
        chk_idle("reset");
        #2 clr = 1'b1;

        do_mul(64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
        do_mul({$urandom, $urandom}, 1'b1);

        do_div(5, 32'd7, 32'd3, 1'b0);
        do_div(T, $urandom, $urandom, 1'b0);
        do_div(0, 32'd0, 32'd0, 1'b1);

        do_mt(1'b1, 32'hDEAD_BEEF);
        do_mt(1'b0, 32'h1234_5678);
        start = 1'b0;
        tick;
        chk_idle("mt.after");

        // Asynchronous reset between edges with HI/LO loaded.
        #2 clr = 1'b0;
        #1;
        m_hi = '0; m_lo = '0;
        chk_flags("areset", 1'b0, 1'b0, 1'b0);
        chk_regs("areset");
        #1 clr = 1'b1;
        do_mul(64'h1, 1'b0);

        // Reset inside the first SETTLE cycle abandons the capture.
        op = 2'b00; start = 1'b1; p_in = {$urandom, $urandom};
        tick;
        start = 1'b0;
        chk_flags("midrst.e0", 1'b1, 1'b0, 1'b0);
        #2 clr = 1'b0;
        #1;
        m_hi = '0; m_lo = '0;
        chk_idle("midrst.low");
        clr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk_idle("midrst.after");
        end

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: do_mul({$urandom, $urandom}, 1'($urandom_range(0, 1)));
                1: do_div($urandom_range(1, T + 2), $urandom, $urandom, 1'($urandom_range(0, 1)));
                default: begin
                    do_mt(1'($urandom_range(0, 1)), $urandom);
                    start = 1'b0;
                    tick;
                    chk_idle("rnd.mt.after");
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hilo_capture.md
# hilo_capture

Result-capture stage directly downstream of the 32-bit Booth multiplier (`multi32`) and the divider in the phase-1 datapath. It owns the HI and LO registers. It waits a programmable number of cycles for the combinational 64-bit product to settle, or handshakes with the divider. It then writes HI/LO and signals completion to the control unit. It also services direct HI/LO writes (mthi/mtlo) and times out a divider that never responds.

## Interface
- `SETTLE_CYCLES`, 2: cycles allowed for `p_in` to settle after `start`; legal range 1..15.
- `DIV_TIMEOUT`, 64: maximum cycles spent waiting for `div_ready`; legal range 1..255.
- `clk`  in  1  sole clock, all state updates on its rising edge.
- `clr`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request from the control unit, sampled at a rising edge.
- `op`  in  2  operation, sampled with `start`: 00 mul, 01 div, 10 mthi, 11 mtlo.
- `p_in`  in  64  product from the multiplier; operands are held stable by the control unit while `busy`.
- `q_in`  in  32  divider quotient.
- `r_in`  in  32  divider remainder.
- `div_ready`  in  1  divider result valid, level.
- `wr_data`  in  32  data for mthi/mtlo.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse: HI/LO were updated at the preceding edge.
- `err`  out  1  one-cycle pulse: divide timed out, HI/LO unchanged.
- `hi_out`  out  32  HI register.
- `lo_out`  out  32  LO register.

## Operation
- States: IDLE, SETTLE, DIVWAIT. Counter `cnt` is 8 bits.
- Reset (`clr` low, any time, including mid-operation): state IDLE, `cnt` 0, `hi_out`/`lo_out` 0, `busy`/`done`/`err` 0. Any in-flight operation is abandoned with no write.
- IDLE, `start`=1:
  - op 00: go to SETTLE with `cnt`=SETTLE_CYCLES-1.
  - op 01: go to DIVWAIT with `cnt`=DIV_TIMEOUT-1.
  - op 10: `hi_out`<=`wr_data`, `done`=1, stay in IDLE.
  - op 11: `lo_out`<=`wr_data`, `done`=1, stay in IDLE.
- SETTLE:
  - If `cnt`==0: {`hi_out`,`lo_out`}<=`p_in`, `done`=1, go to IDLE.
  - Otherwise decrement `cnt`.
- DIVWAIT:
  - If `div_ready`=1: `lo_out`<=`q_in`, `hi_out`<=`r_in`, `done`=1, go to IDLE. This takes priority over timeout.
  - Else if `cnt`==0: `err`=1, go to IDLE.
  - Otherwise decrement `cnt`.
- `busy` = (state != IDLE), registered with the state.
- `start` while `busy`: ignored; no state or register change.
- `start` in the IDLE cycle where `done` or `err` is high: accepted normally (back-to-back).
- `done` and `err` are never high together. Each is high for exactly one cycle per operation.
- No arithmetic is performed here; `p_in` is captured bit-exact. Sign is already in `p_in`[63:32].

## Timing
- Edge E0 samples `start`.
- mul:
  - `busy` is high from after E0 until after E(SETTLE_CYCLES).
  - Capture happens at E(SETTLE_CYCLES).
  - `done` is high during the cycle after the capture edge.
  - Default latency is 2 edges.
- div:
  - Capture happens at the first edge E(k), k≥1, with `div_ready` sampled high.
  - The earliest result is at E1.
  - Timeout `err` is raised at E(DIV_TIMEOUT).
- mthi/mtlo:
  - Write happens at E0.
  - `done` is high during the cycle after E0.
  - `busy` never asserts.
- `div_ready` is ignored outside DIVWAIT. `p_in` is ignored outside the SETTLE edge where `cnt`==0.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- Reset: with HI/LO nonzero, drop `clr` asynchronously between edges.
  - Required: `hi_out`=`lo_out`=0 and `busy`=0 immediately, before the next edge.
  - Deassert `clr`; `start` mul with `p_in`=64'h1 -> `lo_out`=1 after 2 edges.
- mul:
  - `start`, op 00, `p_in`=64'hFFFF_FFFF_FFFF_FFFA (−2×3).
  - Required: `busy` high for 2 cycles, then `hi_out`=32'hFFFF_FFFF and `lo_out`=32'hFFFF_FFFA, `done` pulsing once after E2.
  - Change `p_in` to garbage at E1 -> the value present at E2 is captured.
- div:
  - `start` op 01; raise `div_ready` at E5 with `q_in`=7, `r_in`=3.
  - Required: `lo_out`=7 and `hi_out`=3 after E5, `done` pulses, `err` stays 0.
  - Repeat with `div_ready` and `cnt`==0 on the same edge -> capture, no `err`.
- Timeout:
  - DIV_TIMEOUT=4, `div_ready` held 0.
  - Required: `err` pulses after E4, HI/LO unchanged, `busy` low, and a later `div_ready` pulse has no effect.
- mthi/mtlo and back-to-back:
  - mthi 32'hDEAD_BEEF, then mtlo 32'h1234_5678 on consecutive edges.
  - Required: both written, `done` high 2 consecutive cycles, `busy` stays 0.
  - `start` mul during SETTLE -> ignored, exactly one `done`.
- Reset mid-operation: assert `clr` in SETTLE cycle 1.
  - Required: no capture, `done` never pulses, state IDLE.
